// File: rtl/fp32_maxmin_seq_if.sv
// Stream-in, compare-unit request/response and status bundle for fp32_maxmin_seq.
// The sequencer connects through the slave modport; its environment uses master.
interface fp32_maxmin_seq_if #(
  parameter int LEN_W = 16
);
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_data;
  logic             o_cmp_valid;
  logic [2:0]       o_cmp_op;
  logic [31:0]      o_cmp_a;
  logic [31:0]      o_cmp_b;
  logic             i_cmp_res_valid;
  logic             i_cmp_res;
  logic             i_cmp_nan_err;
  logic             o_busy;
  logic             o_done;
  logic [31:0]      o_max;
  logic [31:0]      o_min;
  logic             o_nan_err;

  modport slave (
    input  i_start, i_len, i_valid, i_data,
    input  i_cmp_res_valid, i_cmp_res, i_cmp_nan_err,
    output o_ready, o_cmp_valid, o_cmp_op, o_cmp_a, o_cmp_b,
    output o_busy, o_done, o_max, o_min, o_nan_err
  );

  modport master (
    output i_start, i_len, i_valid, i_data,
    output i_cmp_res_valid, i_cmp_res, i_cmp_nan_err,
    input  o_ready, o_cmp_valid, o_cmp_op, o_cmp_a, o_cmp_b,
    input  o_busy, o_done, o_max, o_min, o_nan_err
  );
endinterface

// File: rtl/fp32_maxmin_seq.sv
// Running FP32 max/min over an element stream, using an external 2-cycle compare
// unit one request at a time; NaN elements are dropped locally and flagged sticky.
module fp32_maxmin_seq #(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  fp32_maxmin_seq_if.slave   bus
);

  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [2:0]  OP_GT = 3'd1;
  localparam logic [2:0]  OP_LT = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_CMP_MAX,
    S_WAIT_MAX,
    S_CMP_MIN,
    S_WAIT_MIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             have;
  logic [31:0]      elem;
  logic             accept;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  assign accept = (state == S_WAIT_DATA) && bus.i_valid && bus.o_ready;

  // Element under comparison; pure datapath, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      elem <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      have            <= 1'b0;
      bus.o_ready     <= 1'b0;
      bus.o_cmp_valid <= 1'b0;
      bus.o_cmp_op    <= 3'd0;
      bus.o_cmp_a     <= 32'd0;
      bus.o_cmp_b     <= 32'd0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_max       <= 32'd0;
      bus.o_min       <= 32'd0;
      bus.o_nan_err   <= 1'b0;
    end else begin
      // Request and done are single-cycle strobes; request fields idle at zero.
      bus.o_done      <= 1'b0;
      bus.o_cmp_valid <= 1'b0;
      bus.o_cmp_op    <= 3'd0;
      bus.o_cmp_a     <= 32'd0;
      bus.o_cmp_b     <= 32'd0;

      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            cnt           <= bus.i_len;
            have          <= 1'b0;
            bus.o_nan_err <= 1'b0;
            bus.o_max     <= QNAN;
            bus.o_min     <= QNAN;
            bus.o_busy    <= 1'b1;
            if (bus.i_len == '0) begin
              state      <= S_DONE;
              bus.o_done <= 1'b1;
            end else begin
              state       <= S_WAIT_DATA;
              bus.o_ready <= 1'b1;
            end
          end
        end

        S_WAIT_DATA: begin
          if (accept) begin
            cnt <= cnt - 1'b1;
            if (is_nan(bus.i_data) || !have) begin
              if (is_nan(bus.i_data)) begin
                bus.o_nan_err <= 1'b1;
              end else begin
                bus.o_max <= bus.i_data;
                bus.o_min <= bus.i_data;
                have      <= 1'b1;
              end
              // cnt == 1 here means this handshake consumed the last element.
              if (cnt == LEN_W'(1)) begin
                state       <= S_DONE;
                bus.o_ready <= 1'b0;
                bus.o_done  <= 1'b1;
              end
            end else begin
              state           <= S_CMP_MAX;
              bus.o_ready     <= 1'b0;
              bus.o_cmp_valid <= 1'b1;
              bus.o_cmp_op    <= OP_GT;
              bus.o_cmp_a     <= bus.i_data;
              bus.o_cmp_b     <= bus.o_max;
            end
          end
        end

        S_CMP_MAX: begin
          state <= S_WAIT_MAX;
        end

        S_WAIT_MAX: begin
          if (bus.i_cmp_res_valid) begin
            if (!bus.i_cmp_nan_err && !bus.i_cmp_res) begin
              state           <= S_CMP_MIN;
              bus.o_cmp_valid <= 1'b1;
              bus.o_cmp_op    <= OP_LT;
              bus.o_cmp_a     <= elem;
              bus.o_cmp_b     <= bus.o_min;
            end else begin
              // A new maximum cannot also be a new minimum, so skip the LT compare.
              if (bus.i_cmp_nan_err) begin
                bus.o_nan_err <= 1'b1;
              end else begin
                bus.o_max <= elem;
              end
              if (cnt == '0) begin
                state      <= S_DONE;
                bus.o_done <= 1'b1;
              end else begin
                state       <= S_WAIT_DATA;
                bus.o_ready <= 1'b1;
              end
            end
          end
        end

        S_CMP_MIN: begin
          state <= S_WAIT_MIN;
        end

        S_WAIT_MIN: begin
          if (bus.i_cmp_res_valid) begin
            if (bus.i_cmp_res && !bus.i_cmp_nan_err) begin
              bus.o_min <= elem;
            end
            if (cnt == '0) begin
              state      <= S_DONE;
              bus.o_done <= 1'b1;
            end else begin
              state       <= S_WAIT_DATA;
              bus.o_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          bus.o_busy <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          bus.o_busy  <= 1'b0;
          bus.o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_maxmin_seq.sv
// Bench for fp32_maxmin_seq: behavioural compare-unit model with adjustable latency,
// per-scenario tasks, and a total-order reference for max/min.
module tb_fp32_maxmin_seq;
  localparam int LEN_W = 16;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fp32_maxmin_seq_if #(.LEN_W(LEN_W)) bus ();
  fp32_maxmin_seq #(.LEN_W(LEN_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  // IEEE order as an unsigned key: +0 ranks above -0, infinities at the ends.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Compare unit model
  int   lat = 2;
  logic mdl_vld = 1'b0, mdl_res = 1'b0, mdl_nerr = 1'b0, inj_vld = 1'b0;
  logic pend = 1'b0, pres = 1'b0, pnerr = 1'b0;
  int   pcnt = 0;

  always @(posedge clk) begin
    mdl_vld <= 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        mdl_vld  <= 1'b1;
        mdl_res  <= pres;
        mdl_nerr <= pnerr;
        pend     <= 1'b0;
      end else begin
        pcnt <= pcnt - 1;
      end
    end
    if (bus.o_cmp_valid) begin
      pend  <= 1'b1;
      pcnt  <= lat - 1;
      pnerr <= fnan(bus.o_cmp_a) | fnan(bus.o_cmp_b);
      pres  <= (bus.o_cmp_op == 3'd1) ? (fkey(bus.o_cmp_a) > fkey(bus.o_cmp_b)) :
               (bus.o_cmp_op == 3'd3) ? (fkey(bus.o_cmp_a) < fkey(bus.o_cmp_b)) : 1'b0;
    end
  end

  assign bus.i_cmp_res_valid = mdl_vld | inj_vld;
  assign bus.i_cmp_res       = inj_vld ? 1'b1 : mdl_res;
  assign bus.i_cmp_nan_err   = inj_vld ? 1'b0 : mdl_nerr;

  // Bus monitor
  int   cyc = 0, gt_cnt = 0, lt_cnt = 0, bad_op = 0, bad_rep = 0, bad_idle = 0, acc_cnt = 0;
  logic prev_cv = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_cv <= bus.o_cmp_valid;
    if (bus.o_cmp_valid) begin
      if (bus.o_cmp_op == 3'd1) gt_cnt <= gt_cnt + 1;
      else if (bus.o_cmp_op == 3'd3) lt_cnt <= lt_cnt + 1;
      else bad_op <= bad_op + 1;
      if (prev_cv) bad_rep <= bad_rep + 1;
    end else if (bus.o_cmp_a != 32'd0 || bus.o_cmp_b != 32'd0 || bus.o_cmp_op != 3'd0) begin
      bad_idle <= bad_idle + 1;
    end
    if (bus.i_valid && bus.o_ready) acc_cnt <= acc_cnt + 1;
  end

  // Reference: running max/min over the non-NaN elements in arrival order.
  task automatic ref_model(input logic [31:0] d[$], output logic [31:0] emax, output logic [31:0] emin,
                           output logic enan, output int egt, output int elt);
    bit seen = 0;
    emax = QNAN; emin = QNAN; enan = 1'b0; egt = 0; elt = 0;
    foreach (d[i]) begin
      if (fnan(d[i])) enan = 1'b1;
      else if (!seen) begin emax = d[i]; emin = d[i]; seen = 1; end
      else begin
        egt++;
        if (fkey(d[i]) > fkey(emax)) emax = d[i];
        else begin
          elt++;
          if (fkey(d[i]) < fkey(emin)) emin = d[i];
        end
      end
    end
  endtask

  task automatic run(input logic [31:0] d[$], input bit hold, output int dcyc, output bit rdy_seen);
    int s, idx, guard, len;
    bit done_seen;
    len = d.size();
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = LEN_W'(len);
    s = cyc;
    @(negedge clk);
    bus.i_start = 1'b0;
    idx = 0; guard = 0; done_seen = 0; rdy_seen = 0; dcyc = -1;
    while (!done_seen && guard < 3000) begin
      if (bus.o_done) begin done_seen = 1; dcyc = cyc - s; end
      if (bus.o_ready) rdy_seen = 1;
      if (!done_seen && idx < len && (hold || $urandom_range(0, 2) != 0)) begin
        bus.i_valid = 1'b1;
        bus.i_data  = d[idx];
      end else begin
        bus.i_valid = 1'b0;
      end
      if (bus.i_valid && bus.o_ready) idx++;
      @(negedge clk);
      guard++;
    end
    bus.i_valid = 1'b0;
    if (!done_seen) begin
      n_chk++;
      $display("FAIL run_timeout: no o_done after %0d cycles (accepted %0d of %0d)", guard, idx, len);
    end
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.i_len = '0; bus.i_valid = 1'b0; bus.i_data = 32'd0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.o_busy); else n_pass++;
    n_chk++; if (bus.o_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.o_ready); else n_pass++;
    n_chk++; if (bus.o_max !== 32'd0) $display("FAIL reset_max got %h exp 0", bus.o_max); else n_pass++;
    n_chk++; if (bus.o_min !== 32'd0) $display("FAIL reset_min got %h exp 0", bus.o_min); else n_pass++;
    n_chk++; if ({bus.o_done, bus.o_nan_err, bus.o_cmp_valid} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {bus.o_done, bus.o_nan_err, bus.o_cmp_valid}); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input int l, input int exp_cyc, input string tag);
    logic [31:0] d[$];
    logic [31:0] emax, emin;
    logic enan;
    int egt, elt, g0, l0, a0, r0, i0, dcyc;
    bit rs;
    d.push_back(32'h3F80_0000); d.push_back(32'hC000_0000);
    d.push_back(32'h4060_0000); d.push_back(32'h3F00_0000);
    lat = l;
    ref_model(d, emax, emin, enan, egt, elt);
    g0 = gt_cnt; l0 = lt_cnt; a0 = acc_cnt; r0 = bad_rep; i0 = bad_idle;
    run(d, 1'b1, dcyc, rs);
    n_chk++; if (bus.o_max !== emax) $display("FAIL %s_max got %h exp %h", tag, bus.o_max, emax); else n_pass++;
    n_chk++; if (bus.o_min !== emin) $display("FAIL %s_min got %h exp %h", tag, bus.o_min, emin); else n_pass++;
    n_chk++; if (bus.o_nan_err !== enan) $display("FAIL %s_nan got %b exp %b", tag, bus.o_nan_err, enan); else n_pass++;
    n_chk++; if (gt_cnt - g0 != egt) $display("FAIL %s_gt_reqs got %0d exp %0d", tag, gt_cnt - g0, egt); else n_pass++;
    n_chk++; if (lt_cnt - l0 != elt) $display("FAIL %s_lt_reqs got %0d exp %0d", tag, lt_cnt - l0, elt); else n_pass++;
    n_chk++; if (acc_cnt - a0 != 4) $display("FAIL %s_accepts got %0d exp 4", tag, acc_cnt - a0); else n_pass++;
    n_chk++; if (dcyc != exp_cyc) $display("FAIL %s_done_cycle got %0d exp %0d", tag, dcyc, exp_cyc); else n_pass++;
    n_chk++; if (bad_rep - r0 != 0) $display("FAIL %s_req_width got %0d long requests exp 0", tag, bad_rep - r0); else n_pass++;
    n_chk++; if (bad_idle - i0 != 0) $display("FAIL %s_idle_fields got %0d nonzero cycles exp 0", tag, bad_idle - i0); else n_pass++;
  endtask

  task automatic test_nan();
    logic [31:0] d[$];
    int g0, l0, dcyc;
    bit rs;
    d.push_back(32'h7FC0_0001); d.push_back(32'h3F80_0000); d.push_back(32'h7F80_0001);
    lat = 2;
    g0 = gt_cnt; l0 = lt_cnt;
    run(d, 1'b0, dcyc, rs);
    n_chk++; if (bus.o_nan_err !== 1'b1) $display("FAIL nan_flag got %b exp 1", bus.o_nan_err); else n_pass++;
    n_chk++; if (bus.o_max !== 32'h3F80_0000) $display("FAIL nan_max got %h exp 3f800000", bus.o_max); else n_pass++;
    n_chk++; if (bus.o_min !== 32'h3F80_0000) $display("FAIL nan_min got %h exp 3f800000", bus.o_min); else n_pass++;
    n_chk++; if ((gt_cnt - g0) + (lt_cnt - l0) != 0)
      $display("FAIL nan_reqs got %0d exp 0", (gt_cnt - g0) + (lt_cnt - l0)); else n_pass++;
  endtask

  task automatic test_len0();
    logic [31:0] d[$];
    int dcyc;
    bit rs;
    run(d, 1'b0, dcyc, rs);
    n_chk++; if (dcyc != 1) $display("FAIL len0_done_cycle got %0d exp 1", dcyc); else n_pass++;
    n_chk++; if (rs !== 1'b0) $display("FAIL len0_ready_seen got %b exp 0", rs); else n_pass++;
    n_chk++; if (bus.o_max !== QNAN || bus.o_min !== QNAN)
      $display("FAIL len0_maxmin got %h/%h exp %h", bus.o_max, bus.o_min, QNAN); else n_pass++;
    n_chk++; if (bus.o_nan_err !== 1'b0) $display("FAIL len0_nan got %b exp 0", bus.o_nan_err); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL len0_busy_after got %b exp 0", bus.o_busy); else n_pass++;
  endtask

  task automatic test_zero_inf();
    logic [31:0] d[$];
    int dcyc;
    bit rs;
    lat = 3;
    d.push_back(32'h8000_0000); d.push_back(32'h0000_0000);
    run(d, 1'b0, dcyc, rs);
    n_chk++; if (bus.o_max !== 32'h0000_0000) $display("FAIL zero_max got %h exp 00000000", bus.o_max); else n_pass++;
    n_chk++; if (bus.o_min !== 32'h8000_0000) $display("FAIL zero_min got %h exp 80000000", bus.o_min); else n_pass++;
    d.delete();
    d.push_back(32'hFF80_0000); d.push_back(32'h7F80_0000);
    run(d, 1'b1, dcyc, rs);
    n_chk++; if (bus.o_max !== 32'h7F80_0000) $display("FAIL inf_max got %h exp 7f800000", bus.o_max); else n_pass++;
    n_chk++; if (bus.o_min !== 32'hFF80_0000) $display("FAIL inf_min got %h exp ff800000", bus.o_min); else n_pass++;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {r[31], 8'hFF, r[22:0] | 23'd1};
      1: return {r[31], (r[0] ? 8'hFF : 8'h00), 23'd0};
      default: return {r[31], 8'(($urandom_range(100, 154))), r[22:0]};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] d[$];
    logic [31:0] emax, emin;
    logic enan;
    int egt, elt, len, a0, dcyc;
    bit rs;
    for (int k = 0; k < 8; k++) begin
      d.delete();
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) d.push_back(rnd_fp());
      lat = $urandom_range(2, 4);
      ref_model(d, emax, emin, enan, egt, elt);
      a0 = acc_cnt;
      run(d, 1'($urandom_range(0, 1)), dcyc, rs);
      n_chk++; if (bus.o_max !== emax) $display("FAIL rnd%0d_max got %h exp %h", k, bus.o_max, emax); else n_pass++;
      n_chk++; if (bus.o_min !== emin) $display("FAIL rnd%0d_min got %h exp %h", k, bus.o_min, emin); else n_pass++;
      n_chk++; if (bus.o_nan_err !== enan) $display("FAIL rnd%0d_nan got %b exp %b", k, bus.o_nan_err, enan); else n_pass++;
      n_chk++; if (acc_cnt - a0 != len) $display("FAIL rnd%0d_accepts got %0d exp %0d", k, acc_cnt - a0, len); else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d[$];
    logic [31:0] e[2];
    int idx, guard, dcyc;
    bit rs;
    e[0] = 32'h3F80_0000; e[1] = 32'h3F00_0000;
    lat = 5;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_len = LEN_W'(2);
    @(negedge clk);
    bus.i_start = 1'b0;
    idx = 0; guard = 0;
    while (!(bus.o_cmp_valid && bus.o_cmp_op == 3'd3) && guard < 200) begin
      bus.i_valid = (idx < 2);
      bus.i_data  = e[idx & 1];
      if (bus.i_valid && bus.o_ready) idx++;
      @(negedge clk);
      guard++;
    end
    bus.i_valid = 1'b0;
    n_chk++; if (guard >= 200) $display("FAIL rst_reach_min_cmp got timeout exp LT request"); else n_pass++;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL rst_mid_ctrl got busy=%b ready=%b done=%b exp 0", bus.o_busy, bus.o_ready, bus.o_done); else n_pass++;
    n_chk++; if (bus.o_max !== 32'd0 || bus.o_min !== 32'd0 || bus.o_nan_err !== 1'b0)
      $display("FAIL rst_mid_data got %h/%h/%b exp 0", bus.o_max, bus.o_min, bus.o_nan_err); else n_pass++;
    n_chk++; if (bus.o_cmp_valid !== 1'b0 || bus.o_cmp_a !== 32'd0)
      $display("FAIL rst_mid_cmp got %b/%h exp 0", bus.o_cmp_valid, bus.o_cmp_a); else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_max !== 32'd0 || bus.o_min !== 32'd0 || bus.o_nan_err !== 1'b0)
      $display("FAIL rst_stale_result got busy=%b %h/%h/%b exp 0", bus.o_busy, bus.o_max, bus.o_min, bus.o_nan_err); else n_pass++;
    lat = 2;
    d.push_back(32'h4000_0000);
    run(d, 1'b1, dcyc, rs);
    n_chk++; if (bus.o_max !== 32'h4000_0000 || bus.o_min !== 32'h4000_0000)
      $display("FAIL rst_newrun got %h/%h exp 40000000", bus.o_max, bus.o_min); else n_pass++;
    n_chk++; if (bus.o_nan_err !== 1'b0) $display("FAIL rst_newrun_nan got %b exp 0", bus.o_nan_err); else n_pass++;
  endtask

  task automatic test_bus_hygiene();
    n_chk++; if (bad_op != 0) $display("FAIL cmp_op_legal got %0d bad requests exp 0", bad_op); else n_pass++;
    n_chk++; if (bad_rep != 0) $display("FAIL cmp_single_cycle got %0d long requests exp 0", bad_rep); else n_pass++;
    n_chk++; if (bad_idle != 0) $display("FAIL cmp_idle_zero got %0d cycles exp 0", bad_idle); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic(2, 20, "seq_fast");
    test_nan();
    test_len0();
    test_zero_inf();
    test_basic(5, 35, "seq_slow");
    test_random();
    test_reset_midrun();
    test_bus_hygiene();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
